// File: rtl/p2r_pkg.sv
// Shared types and constants for the polar-to-rectangular CORDIC.
// Angles are 16-bit signed in units of 1/128 degree.
package p2r_pkg;

  typedef enum logic [1:0] {IDLE, PRESCALE, ROTATE, DONE} state_t;

  localparam int ITER_MAX  = 12;
  localparam int CNT_W     = $clog2(ITER_MAX + 1);
  localparam int ANG_W     = 16;
  localparam int ANG_SCALE = 128;

  localparam logic signed [ANG_W-1:0] ANG_90  = 16'sd11520;
  localparam logic signed [ANG_W-1:0] ANG_180 = 16'sd23040;

  // Gain compensation K ~ 0.6074 as a sum of shifted radius terms.
  localparam int K_TERMS = 5;
  localparam int K_SHIFT [K_TERMS] = '{1, 3, 6, 9, 13};
  localparam logic [K_TERMS-1:0] K_SUB = 5'b11100;  // bit i set: term i is subtracted

  function automatic logic signed [ANG_W-1:0] atan_of(input logic [CNT_W-1:0] i);
    case (i)
      4'd0:    atan_of = 16'sd5760;
      4'd1:    atan_of = 16'sd3400;
      4'd2:    atan_of = 16'sd1797;
      4'd3:    atan_of = 16'sd912;
      4'd4:    atan_of = 16'sd458;
      4'd5:    atan_of = 16'sd229;
      4'd6:    atan_of = 16'sd115;
      4'd7:    atan_of = 16'sd57;
      4'd8:    atan_of = 16'sd29;
      4'd9:    atan_of = 16'sd14;
      4'd10:   atan_of = 16'sd7;
      4'd11:   atan_of = 16'sd4;
      default: atan_of = 16'sd0;
    endcase
  endfunction

endpackage

// File: rtl/p2r_micro_rot.sv
// One rotation-mode CORDIC micro-rotation, purely combinational.
module p2r_micro_rot
  import p2r_pkg::*;
#(
  parameter int DW = 34
) (
  input  logic signed [DW-1:0]    x_in,
  input  logic signed [DW-1:0]    y_in,
  input  logic signed [ANG_W-1:0] z_in,
  input  logic [CNT_W-1:0]        shift,
  input  logic signed [ANG_W-1:0] atan,
  output logic signed [DW-1:0]    x_next,
  output logic signed [DW-1:0]    y_next,
  output logic signed [ANG_W-1:0] z_next
);

  logic signed [DW-1:0] x_sh;
  logic signed [DW-1:0] y_sh;
  logic                 rot_pos;

  assign x_sh    = x_in >>> shift;
  assign y_sh    = y_in >>> shift;
  assign rot_pos = ~z_in[ANG_W-1];

  assign x_next = rot_pos ? (x_in - y_sh) : (x_in + y_sh);
  assign y_next = rot_pos ? (y_in + x_sh) : (y_in - x_sh);
  assign z_next = rot_pos ? (z_in - atan) : (z_in + atan);

endmodule

// File: rtl/p2r_cordic.sv
// Iterative polar-to-rectangular converter: radius/degree angle in, signed x/y out,
// one micro-rotation per cycle behind valid/ready handshakes.
module p2r_cordic
  import p2r_pkg::*;
#(
  parameter int WIDTH = 31,
  parameter int ITER  = 12,
  parameter int GUARD = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WIDTH:0] radius,
  input  logic [8:0]     angle,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WIDTH:0] x_out,
  output logic [WIDTH:0] y_out
);

  localparam int DW   = WIDTH + 1 + GUARD;
  localparam int A_SH = $clog2(ANG_SCALE);
  localparam logic [CNT_W-1:0]     LAST    = CNT_W'(ITER - 1);
  localparam logic signed [DW-1:0] SAT_MAX = {{(GUARD + 1){1'b0}}, {WIDTH{1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {{(GUARD + 1){1'b1}}, {WIDTH{1'b0}}};

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg;
  logic [WIDTH:0]          radius_reg;
  logic signed [DW-1:0]    x_reg, y_reg;
  logic signed [ANG_W-1:0] z_reg;
  logic                    neg_reg;
  logic [WIDTH:0]          x_out_reg, y_out_reg;

  // Angle wrap into [-180,180], then fold outer quadrants into [-90,90].
  logic signed [9:0]       a_ext, a_red;
  logic signed [ANG_W-1:0] z_fp, z_cap;
  logic                    neg_cap;

  always_comb begin
    a_ext = {angle[8], angle};
    a_red = a_ext;
    if (a_ext > 10'sd180)
      a_red = a_ext - 10'sd360;
    else if (a_ext < -10'sd180)
      a_red = a_ext + 10'sd360;
    z_fp    = {{(ANG_W - 10){a_red[9]}}, a_red} <<< A_SH;
    z_cap   = z_fp;
    neg_cap = 1'b0;
    if (z_fp > ANG_90) begin
      z_cap   = z_fp - ANG_180;
      neg_cap = 1'b1;
    end else if (z_fp < -ANG_90) begin
      z_cap   = z_fp + ANG_180;
      neg_cap = 1'b1;
    end
  end

  logic [DW-1:0] r_ext;
  logic [DW-1:0] k_term [K_TERMS];
  logic [DW-1:0] r_scaled;

  assign r_ext = {{GUARD{1'b0}}, radius_reg};

  generate
    for (genvar gi = 0; gi < K_TERMS; gi++) begin : g_k
      assign k_term[gi] = r_ext >> K_SHIFT[gi];
    end
  endgenerate

  // Additive terms come first in the list, so the unsigned sum never underflows.
  always_comb begin
    r_scaled = '0;
    for (int i = 0; i < K_TERMS; i++)
      r_scaled = K_SUB[i] ? (r_scaled - k_term[i]) : (r_scaled + k_term[i]);
  end

  logic signed [ANG_W-1:0] atan_val;
  logic signed [DW-1:0]    x_rot, y_rot;
  logic signed [ANG_W-1:0] z_rot;

  assign atan_val = atan_of(cnt_reg);

  p2r_micro_rot #(.DW(DW)) u_rot (
    .x_in   (x_reg),
    .y_in   (y_reg),
    .z_in   (z_reg),
    .shift  (cnt_reg),
    .atan   (atan_val),
    .x_next (x_rot),
    .y_next (y_rot),
    .z_next (z_rot)
  );

  logic signed [DW-1:0] x_fix, y_fix;
  assign x_fix = neg_reg ? -x_rot : x_rot;
  assign y_fix = neg_reg ? -y_rot : y_rot;

  function automatic logic [WIDTH:0] sat(input logic signed [DW-1:0] v);
    if (v > SAT_MAX)
      sat = {1'b0, {WIDTH{1'b1}}};
    else if (v < SAT_MIN)
      sat = {1'b1, {WIDTH{1'b0}}};
    else
      sat = v[WIDTH:0];
  endfunction

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (in_valid) state_next = PRESCALE;
      PRESCALE: state_next = ROTATE;
      ROTATE:   if (cnt_reg == LAST) state_next = DONE;
      DONE:     if (out_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      radius_reg <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      z_reg      <= '0;
      neg_reg    <= 1'b0;
      x_out_reg  <= '0;
      y_out_reg  <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            radius_reg <= radius;
            z_reg      <= z_cap;
            neg_reg    <= neg_cap;
          end
        end
        PRESCALE: begin
          x_reg   <= r_scaled;
          y_reg   <= '0;
          cnt_reg <= '0;
        end
        ROTATE: begin
          x_reg   <= x_rot;
          y_reg   <= y_rot;
          z_reg   <= z_rot;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST) begin
            x_out_reg <= sat(x_fix);
            y_out_reg <= sat(y_fix);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign x_out     = x_out_reg;
  assign y_out     = y_out_reg;

endmodule

// File: tb/tb_p2r_cordic.sv
// Scoreboard bench for p2r_cordic: expected x/y come from trigonometry on the
// requested radius/angle, with the stated accuracy envelope and saturation.
module tb_p2r_cordic;

  localparam int  WIDTH = 31;
  localparam int  ITER  = 12;
  localparam int  GUARD = 2;
  localparam int  LAT   = ITER + 1;  // edges after the accept edge (14th edge counting it)
  localparam real PI    = 3.14159265358979;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [WIDTH:0] radius = '0;
  logic [8:0]     angle = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [WIDTH:0] x_out;
  logic [WIDTH:0] y_out;

  int     total = 0;
  int     bad = 0;
  longint cyc = 0;
  longint accept_cyc = 0;
  bit     busy, ready_bad, ov_prev;

  typedef struct {
    longint r;
    int     a;
    real    ex;
    real    ey;
    real    tol;
  } exp_t;

  exp_t   q[$];
  longint x_log[$];
  longint y_log[$];

  p2r_cordic #(.WIDTH(WIDTH), .ITER(ITER), .GUARD(GUARD)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .radius    (radius),
    .angle     (angle),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic real clampv(input real v);
    if (v > 2147483647.0) return 2147483647.0;
    if (v < -2147483648.0) return -2147483648.0;
    return v;
  endfunction

  function automatic exp_t model(input longint r, input int a);
    exp_t e;
    real  th;
    th    = a * PI / 180.0;
    e.r   = r;
    e.a   = a;
    e.ex  = clampv(real'(r) * $cos(th));
    e.ey  = clampv(real'(r) * $sin(th));
    e.tol = real'(r) / 1024.0 + 4.0;
    return e;
  endfunction

  function automatic bit near(input longint act, input real ex, input real tol);
    real d;
    d = real'(act) - ex;
    if (d < 0.0) d = -d;
    return d <= tol;
  endfunction

  task automatic send(input longint r, input int a);
    int w;
    w = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    radius   = r[WIDTH:0];
    angle    = a[8:0];
    while (!in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    chk(in_ready, "accept_wait", longint'(in_ready), 1);
    if (in_ready) q.push_back(model(r, a));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((q.size() != 0 || out_valid) && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    chk(q.size() == 0, "drain", q.size(), 0);
  endtask

  // Monitor: samples on the falling edge, pops and checks on each handshake.
  initial begin
    exp_t   e;
    longint xs, ys;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 1'b0; ready_bad = 1'b0; ov_prev = 1'b0;
      end else begin
        if (busy && in_ready) ready_bad = 1'b1;
        if (out_valid && !ov_prev)
          chk(cyc - accept_cyc == LAT, "latency", cyc - accept_cyc, LAT);
        if (out_valid && out_ready) begin
          chk(q.size() != 0, "output_expected", q.size(), 1);
          if (q.size() != 0) begin
            e  = q.pop_front();
            xs = longint'($signed(x_out));
            ys = longint'($signed(y_out));
            $display("txn r=%0d a=%0d x=%0d y=%0d exp_x=%0.1f exp_y=%0.1f", e.r, e.a, xs, ys, e.ex, e.ey);
            chk(near(xs, e.ex, e.tol), "x_out", xs, longint'(e.ex));
            chk(near(ys, e.ey, e.tol), "y_out", ys, longint'(e.ey));
            chk(!ready_bad, "in_ready_low", longint'(ready_bad), 0);
            x_log.push_back(xs);
            y_log.push_back(ys);
          end
          busy = 1'b0; ready_bad = 1'b0;
        end
        if (in_valid && in_ready) begin
          busy = 1'b1;
          accept_cyc = cyc + 1;
        end
        ov_prev = out_valid;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: actual=%0d required=0", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    exp_t   e;
    longint r;
    int     a, w;

    repeat (3) @(posedge clk);
    #1;
    chk(out_valid == 1'b0, "rst_out_valid", longint'(out_valid), 0);
    chk(x_out == '0, "rst_x_out", longint'(x_out), 0);
    chk(y_out == '0, "rst_y_out", longint'(y_out), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk(in_ready == 1'b1, "rst_in_ready", longint'(in_ready), 1);

    // Directed axis points, -135, 200 vs -160, and positive saturation.
    send(1000, 0);
    send(1000, 90);
    send(1000, 180);
    send(1000, -90);
    send(1 << 30, -135);
    send(1 << 30, 200);
    send(1 << 30, -160);
    send(2147483647, 0);
    drain();
    chk(x_log.size() == 8, "directed_count", x_log.size(), 8);
    if (x_log.size() >= 8) begin
      chk(x_log[5] == x_log[6], "ang200_x", x_log[5], x_log[6]);
      chk(y_log[5] == y_log[6], "ang200_y", y_log[5], y_log[6]);
      chk(x_log[7] == 2147483647, "sat_x", x_log[7], 2147483647);
    end

    // Back-pressure: hold out_ready low, poke in_valid, then release.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(5000, 30);
    w = 0;
    while (!out_valid && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk(out_valid, "hold_valid_rise", longint'(out_valid), 1);
    e = model(5000, 30);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      radius   = 32'd123;
      angle    = 9'd45;
      @(posedge clk); #1;
      chk(out_valid == 1'b1, "hold_out_valid", longint'(out_valid), 1);
      chk(in_ready == 1'b0, "hold_in_ready", longint'(in_ready), 0);
      chk(near(longint'($signed(x_out)), e.ex, e.tol), "hold_x", longint'($signed(x_out)), longint'(e.ex));
      chk(near(longint'($signed(y_out)), e.ey, e.tol), "hold_y", longint'($signed(y_out)), longint'(e.ey));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk(in_ready == 1'b1, "release_in_ready", longint'(in_ready), 1);
    chk(out_valid == 1'b0, "release_out_valid", longint'(out_valid), 0);
    send(777, -45);
    drain();

    // Reset while rotating (counter at 5): nothing partial may come out.
    send(1000, 45);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    chk(out_valid == 1'b0, "midrst_out_valid", longint'(out_valid), 0);
    chk(x_out == '0, "midrst_x_out", longint'(x_out), 0);
    chk(y_out == '0, "midrst_y_out", longint'(y_out), 0);
    chk(in_ready == 1'b1, "midrst_in_ready", longint'(in_ready), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk(in_ready == 1'b1, "post_rst_in_ready", longint'(in_ready), 1);
    send(1000, 45);
    drain();

    // Randomised radius/angle over the full input ranges.
    for (int t = 0; t < 30; t++) begin
      r = longint'($urandom);
      if (t < 10) r = r >> 16;
      a = int'($urandom_range(0, 511)) - 256;
      send(r, a);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
